sseg_scan_decoder: RTL and testbench
====================================

SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYCLES, default 4, the number of consecutive clock edges the an/sseg inputs must stay unchanged before a digit is captured (legal range 2..255).
REQ-002 clk  in  1  single system clock; all state SHALL be on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 an  in  4  anode enables from a time-multiplexed display driver, active-low; bit i selects digit i.
REQ-005 sseg  in  8  segment lines, active-low; bit 7 = dp, bits 6:0 = {g,f,e,d,c,b,a}.
REQ-006 hex0..hex3  out  4 each  last legally decoded value of digits 0..3.
REQ-007 dp_out  out  4  last captured decimal point per digit; 1 = lit.
REQ-008 digit_valid  out  4  bit i = 1 when the last capture of digit i decoded to a legal pattern.
REQ-009 frame_done  out  1  one-cycle pulse when all four digits have been captured since the previous pulse.
REQ-010 err  out  1  one-cycle pulse on an illegal anode or segment pattern.

Function
REQ-011 an and sseg SHALL be registered once (stage R) before any other use; the stability comparison is made between R and the previous R value.
REQ-012 The settle counter SHALL clear to 0 when R differs from its previous value, increment when unchanged, and saturate at SETTLE_CYCLES.
REQ-013 A capture event SHALL occur only on the edge at which the counter goes from SETTLE_CYCLES-1 to SETTLE_CYCLES, i.e. once per stable period; it SHALL NOT repeat while the inputs stay stable.
REQ-014 Outputs SHALL reflect a capture on the edge after the capture event, giving SETTLE_CYCLES+2 edges of latency from an input change held stable.
REQ-015 Anode handling at a capture event:
- an = 4'b1111 (blanked): no capture, no err.
- Exactly one bit low: capture that digit.
- Two or more bits low: err pulse, and no state change.
REQ-016 Legal sseg[6:0] patterns SHALL decode as follows:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-017 On a legal capture of digit i, the block SHALL load hexi, set dp_out[i] = ~sseg[7], and set digit_valid[i] = 1.
REQ-018 On an illegal pattern for digit i, the block SHALL hold hexi, still load dp_out[i], clear digit_valid[i], and pulse err.
REQ-019 A 4-bit seen mask SHALL set bit i on every capture of digit i, whether legal or illegal; a recapture of an already-seen digit SHALL leave the mask unchanged.
REQ-020 When a capture makes the mask 4'b1111, frame_done SHALL pulse on that capture's output edge and the mask SHALL clear to 0000 on the same edge.
REQ-021 err and frame_done SHALL both pulse on the same edge when the completing capture is illegal.

Reset
REQ-022 Asserting rst low SHALL immediately and asynchronously force every output to the following values:
- hex0..hex3 = 0, dp_out = 0, digit_valid = 0
- frame_done = 0, err = 0
REQ-023 While rst is low, stage R SHALL be forced to an = 1111 and sseg = 8'hFF, and the settle counter and seen mask SHALL be forced to 0.
REQ-024 A reset asserted mid-settle or mid-frame SHALL discard the partial count and mask; decoding SHALL restart cleanly from the first rising edge after rst is released.

Verification (SETTLE_CYCLES = 4)
REQ-025 Hold an=1110, sseg=8'b1010_0100 -> after 6 edges: hex0=2, dp_out[0]=0, digit_valid[0]=1, no err; no further capture while held.
REQ-026 Scan digits 0..3 with 3, F, 8, 1 (dp lit on digit 2), 8 cycles each -> hex0..3=3,F,8,1; dp_out=0100; exactly one frame_done pulse.
REQ-027 Change sseg after 2 stable cycles, then hold -> no capture from the glitch; the single capture uses the final value.
REQ-028 an=1100 held -> one err pulse and no output change; an=1111 held -> no err and no change.
REQ-029 Digit 1 with illegal sseg[6:0]=1111111 -> err pulse, hex1 held, digit_valid[1]=0; mask bit 1 set so the frame can still complete.
REQ-030 Drive rst low mid-frame after 2 digits -> all outputs 0 at once; after release, two more digits alone SHALL NOT produce frame_done.

Source files
------------

// File: rtl/sseg_scan_decoder.sv
// Recovers the hex digits, decimal points and frame timing shown on a
// time-multiplexed, active-low 4-digit seven-segment display.
module sseg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] dp_out,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       err
);

  localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE_CYCLES);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    AN_BLANK,
    AN_SINGLE,
    AN_MULTI
  } an_class_t;

  logic [3:0] r_an;
  logic [7:0] r_sseg;
  logic [3:0] r_an_prev;
  logic [7:0] r_sseg_prev;
  logic [7:0] r_cnt;
  logic [3:0] r_mask;
  logic [3:0] r_hex [4];
  logic [3:0] r_dp;
  logic [3:0] r_valid;
  logic       r_err;
  logic       r_fd;

  logic       w_chg;
  logic       w_cap;
  an_class_t  w_class;
  logic [1:0] w_digit;
  logic       w_legal;
  logic [3:0] w_val;
  logic [3:0] w_mask_next;

  assign w_chg = (r_an != r_an_prev) || (r_sseg != r_sseg_prev);
  // Fires only on the 1-cycle step into saturation, so a long stable period yields one capture.
  assign w_cap = !w_chg && (r_cnt == SETTLE_LAST);
  assign w_mask_next = r_mask | (4'b0001 << w_digit);

  always_comb begin
    w_class = AN_MULTI;
    w_digit = '0;
    case (r_an)
      4'b1111: w_class = AN_BLANK;
      4'b1110: begin w_class = AN_SINGLE; w_digit = 2'd0; end
      4'b1101: begin w_class = AN_SINGLE; w_digit = 2'd1; end
      4'b1011: begin w_class = AN_SINGLE; w_digit = 2'd2; end
      4'b0111: begin w_class = AN_SINGLE; w_digit = 2'd3; end
      default: w_class = AN_MULTI;
    endcase
  end

  always_comb begin
    w_legal = 1'b1;
    w_val   = '0;
    case (r_sseg[6:0])
      7'b1000000: w_val = 4'h0;
      7'b1111001: w_val = 4'h1;
      7'b0100100: w_val = 4'h2;
      7'b0110000: w_val = 4'h3;
      7'b0011001: w_val = 4'h4;
      7'b0010010: w_val = 4'h5;
      7'b0000010: w_val = 4'h6;
      7'b1111000: w_val = 4'h7;
      7'b0000000: w_val = 4'h8;
      7'b0010000: w_val = 4'h9;
      7'b0001000: w_val = 4'hA;
      7'b0000011: w_val = 4'hB;
      7'b1000110: w_val = 4'hC;
      7'b0100001: w_val = 4'hD;
      7'b0000110: w_val = 4'hE;
      7'b0001110: w_val = 4'hF;
      default:    w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an        <= '1;
      r_sseg      <= '1;
      r_an_prev   <= '1;
      r_sseg_prev <= '1;
      r_cnt       <= '0;
      r_mask      <= '0;
      for (int unsigned i = 0; i < 4; i++) r_hex[i] <= '0;
      r_dp        <= '0;
      r_valid     <= '0;
      r_err       <= 1'b0;
      r_fd        <= 1'b0;
    end else begin
      r_an        <= an;
      r_sseg      <= sseg;
      r_an_prev   <= r_an;
      r_sseg_prev <= r_sseg;

      if (w_chg)
        r_cnt <= '0;
      else if (r_cnt != SETTLE_MAX)
        r_cnt <= r_cnt + 8'd1;

      r_err <= 1'b0;
      r_fd  <= 1'b0;

      if (w_cap) begin
        case (w_class)
          AN_SINGLE: begin
            r_dp[w_digit] <= ~r_sseg[7];
            if (w_legal) begin
              r_hex[w_digit]   <= w_val;
              r_valid[w_digit] <= 1'b1;
            end else begin
              r_valid[w_digit] <= 1'b0;
              r_err            <= 1'b1;
            end
            if (w_mask_next == 4'b1111) begin
              r_fd   <= 1'b1;
              r_mask <= '0;
            end else begin
              r_mask <= w_mask_next;
            end
          end
          AN_MULTI: r_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign hex0        = r_hex[0];
  assign hex1        = r_hex[1];
  assign hex2        = r_hex[2];
  assign hex3        = r_hex[3];
  assign dp_out      = r_dp;
  assign digit_valid = r_valid;
  assign frame_done  = r_fd;
  assign err         = r_err;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Scoreboard bench for sseg_scan_decoder: a behavioural model queues the
// expected output state per held pattern and it is compared at capture time.
module tb_sseg_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [3:0] hex0, hex1, hex2, hex3;
  logic [3:0] dp_out;
  logic [3:0] digit_valid;
  logic       frame_done;
  logic       err;

  sseg_scan_decoder #(.SETTLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .an         (an),
    .sseg       (sseg),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .dp_out     (dp_out),
    .digit_valid(digit_valid),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned p_err  = 0;
  int unsigned p_fd   = 0;

  logic [25:0] sb_q [$];
  logic [3:0]  m_hex [4];
  logic [3:0]  m_dp, m_valid, m_mask;

  always @(negedge clk) begin
    if (err === 1'b1) p_err++;
    if (frame_done === 1'b1) p_fd++;
  end

  function automatic logic [25:0] obs();
    return {hex3, hex2, hex1, hex0, dp_out, digit_valid, err, frame_done};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_hex[i] = '0;
    m_dp = '0; m_valid = '0; m_mask = '0;
    sb_q.delete();
  endtask

  // Expected post-capture state for a pattern held long enough to settle.
  task automatic model_step(input logic [3:0] a, input logic [7:0] s);
    logic e_err, e_fd, legal;
    logic [3:0] v;
    int idx;
    e_err = 1'b0; e_fd = 1'b0; legal = 1'b0; v = '0; idx = 0;
    if ($countones(~a) == 1) begin
      for (int i = 0; i < 4; i++) if (a[i] == 1'b0) idx = i;
      for (int k = 0; k < 16; k++) if (SEG_TAB[k] == s[6:0]) begin legal = 1'b1; v = 4'(k); end
      m_dp[idx] = ~s[7];
      if (legal) begin m_hex[idx] = v; m_valid[idx] = 1'b1; end
      else begin m_valid[idx] = 1'b0; e_err = 1'b1; end
      m_mask[idx] = 1'b1;
      if (m_mask == 4'b1111) begin e_fd = 1'b1; m_mask = '0; end
    end else if ($countones(~a) >= 2) begin
      e_err = 1'b1;
    end
    sb_q.push_back({m_hex[3], m_hex[2], m_hex[1], m_hex[0], m_dp, m_valid, e_err, e_fd});
  endtask

  task automatic drive_raw(input logic [3:0] a, input logic [7:0] s);
    an = a; sseg = s;
  endtask

  task automatic drive(input logic [3:0] a, input logic [7:0] s);
    an = a; sseg = s;
    model_step(a, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; an = 4'hF; sseg = 8'hFF;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; an = 4'hF; sseg = 8'hFF;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (obs() !== 26'h0) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs(), 26'h0); end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (obs() !== 26'h0 || p_err != 0 || p_fd != 0) begin
      errors++; $display("FAIL idle_blank: got %h err=%0d fd=%0d expected 0 with no pulses", obs(), p_err, p_fd);
    end
  endtask

  task automatic test_single();
    logic [25:0] e_vec;
    int unsigned e0, f0;
    do_reset();
    e0 = p_err; f0 = p_fd;
    drive(4'b1110, 8'b1010_0100);
    repeat (5) @(negedge clk);
    checks++;
    if (obs() !== 26'h0) begin errors++; $display("FAIL single_early: got %h expected %h", obs(), 26'h0); end
    @(negedge clk);
    e_vec = sb_q.pop_front();
    checks++;
    if (obs() !== e_vec) begin errors++; $display("FAIL single_capture: got %h expected %h", obs(), e_vec); end
    checks++;
    if (hex0 !== 4'h2 || dp_out[0] !== 1'b0 || digit_valid[0] !== 1'b1) begin
      errors++; $display("FAIL single_digit0: got hex0=%h dp=%b valid=%b expected 2 0 1", hex0, dp_out[0], digit_valid[0]);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (p_err - e0 != 0 || p_fd - f0 != 0 || obs() !== {e_vec[25:2], 2'b00}) begin
      errors++; $display("FAIL single_no_repeat: got %h err=%0d fd=%0d expected %h no pulses", obs(), p_err - e0, p_fd - f0, {e_vec[25:2], 2'b00});
    end
  endtask

  task automatic test_scan();
    logic [3:0] a_t [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] s_t [4] = '{8'hB0, 8'h8E, 8'h00, 8'hF9};
    logic [25:0] e_vec;
    int unsigned e0, f0;
    do_reset();
    e0 = p_err; f0 = p_fd;
    for (int i = 0; i < 4; i++) begin
      drive(a_t[i], s_t[i]);
      repeat (6) @(negedge clk);
      e_vec = sb_q.pop_front();
      checks++;
      if (obs() !== e_vec) begin errors++; $display("FAIL scan_step%0d: got %h expected %h", i, obs(), e_vec); end
      repeat (2) @(negedge clk);
    end
    checks++;
    if (obs() !== {4'h1, 4'h8, 4'hF, 4'h3, 4'b0100, 4'b1111, 1'b0, 1'b0}) begin
      errors++; $display("FAIL scan_final: got %h expected %h", obs(), {4'h1, 4'h8, 4'hF, 4'h3, 4'b0100, 4'b1111, 1'b0, 1'b0});
    end
    checks++;
    if (p_fd - f0 != 1 || p_err - e0 != 0) begin
      errors++; $display("FAIL scan_pulses: got fd=%0d err=%0d expected fd=1 err=0", p_fd - f0, p_err - e0);
    end
  endtask

  task automatic test_glitch();
    logic [25:0] e_vec;
    int unsigned e0, f0;
    do_reset();
    e0 = p_err; f0 = p_fd;
    drive_raw(4'b1110, 8'hC0);
    repeat (2) @(negedge clk);
    drive(4'b1110, 8'hF9);
    repeat (4) @(negedge clk);
    checks++;
    if (obs() !== 26'h0) begin errors++; $display("FAIL glitch_nocap: got %h expected %h", obs(), 26'h0); end
    repeat (2) @(negedge clk);
    e_vec = sb_q.pop_front();
    checks++;
    if (obs() !== e_vec) begin errors++; $display("FAIL glitch_final: got %h expected %h", obs(), e_vec); end
    repeat (8) @(negedge clk);
    checks++;
    if (p_err - e0 != 0 || p_fd - f0 != 0 || hex0 !== 4'h1) begin
      errors++; $display("FAIL glitch_single: got hex0=%h err=%0d fd=%0d expected 1 0 0", hex0, p_err - e0, p_fd - f0);
    end
  endtask

  task automatic test_anode();
    logic [25:0] e_vec;
    int unsigned e0, f0;
    do_reset();
    e0 = p_err; f0 = p_fd;
    drive(4'b1100, 8'hC0);
    repeat (6) @(negedge clk);
    e_vec = sb_q.pop_front();
    checks++;
    if (obs() !== e_vec) begin errors++; $display("FAIL multi_anode: got %h expected %h", obs(), e_vec); end
    repeat (6) @(negedge clk);
    checks++;
    if (p_err - e0 != 1) begin errors++; $display("FAIL multi_anode_once: got err=%0d expected 1", p_err - e0); end
    drive(4'b1111, 8'h80);
    repeat (6) @(negedge clk);
    e_vec = sb_q.pop_front();
    checks++;
    if (obs() !== e_vec) begin errors++; $display("FAIL blank_anode: got %h expected %h", obs(), e_vec); end
    repeat (6) @(negedge clk);
    checks++;
    if (p_err - e0 != 1 || p_fd - f0 != 0) begin
      errors++; $display("FAIL blank_pulses: got err=%0d fd=%0d expected 1 0", p_err - e0, p_fd - f0);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] a_t [5] = '{4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] s_t [5] = '{8'hC0, 8'hF9, 8'h7F, 8'hA4, 8'hFF};
    logic [25:0] e_vec;
    int unsigned e0, f0;
    do_reset();
    e0 = p_err; f0 = p_fd;
    for (int i = 0; i < 5; i++) begin
      drive(a_t[i], s_t[i]);
      repeat (6) @(negedge clk);
      e_vec = sb_q.pop_front();
      checks++;
      if (obs() !== e_vec) begin errors++; $display("FAIL illegal_step%0d: got %h expected %h", i, obs(), e_vec); end
      repeat (2) @(negedge clk);
    end
    checks++;
    if (obs() !== {4'h0, 4'h2, 4'h1, 4'h0, 4'b0010, 4'b0101, 1'b0, 1'b0}) begin
      errors++; $display("FAIL illegal_final: got %h expected %h", obs(), {4'h0, 4'h2, 4'h1, 4'h0, 4'b0010, 4'b0101, 1'b0, 1'b0});
    end
    checks++;
    if (p_err - e0 != 2 || p_fd - f0 != 1) begin
      errors++; $display("FAIL illegal_pulses: got err=%0d fd=%0d expected 2 1", p_err - e0, p_fd - f0);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] a_t [2] = '{4'b1110, 4'b1101};
    logic [7:0] s_t [2] = '{8'h30, 8'h19};
    logic [3:0] b_t [2] = '{4'b1011, 4'b0111};
    logic [7:0] t_t [2] = '{8'h12, 8'hF8};
    logic [25:0] e_vec;
    int unsigned f0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(a_t[i], s_t[i]);
      repeat (6) @(negedge clk);
      e_vec = sb_q.pop_front();
      checks++;
      if (obs() !== e_vec) begin errors++; $display("FAIL pre_reset_step%0d: got %h expected %h", i, obs(), e_vec); end
      repeat (2) @(negedge clk);
    end
    drive_raw(4'b1011, 8'h12);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== 26'h0) begin errors++; $display("FAIL async_reset: got %h expected %h", obs(), 26'h0); end
    an = 4'hF; sseg = 8'hFF;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    f0 = p_fd;
    for (int i = 0; i < 2; i++) begin
      drive(b_t[i], t_t[i]);
      repeat (6) @(negedge clk);
      e_vec = sb_q.pop_front();
      checks++;
      if (obs() !== e_vec) begin errors++; $display("FAIL post_reset_step%0d: got %h expected %h", i, obs(), e_vec); end
      repeat (2) @(negedge clk);
    end
    checks++;
    if (p_fd - f0 != 0) begin errors++; $display("FAIL post_reset_no_frame: got fd=%0d expected 0", p_fd - f0); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    an = 4'hF; sseg = 8'hFF;
    test_reset();
    test_single();
    test_scan();
    test_glitch();
    test_anode();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
